// File: rtl/hex_display_ctrl_if.sv
// Switch/button inputs and seven-segment outputs of hex_display_ctrl.
// The board top drives sw/freeze_btn; the controller drives hex/frozen/changed.
interface hex_display_ctrl_if #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned DIGITS = 3
);
    logic [WIDTH-1:0]    sw;
    logic                freeze_btn;
    logic [7*DIGITS-1:0] hex;
    logic                frozen;
    logic                changed;

    modport master (
        output sw,
        output freeze_btn,
        input  hex,
        input  frozen,
        input  changed
    );

    modport slave (
        input  sw,
        input  freeze_btn,
        output hex,
        output frozen,
        output changed
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Synchronised, debounced switch value shown on active-low hex digits, with freeze button.
// Optional macro HEX_BLANK_EN: blank leading zero digits (digit 0 always shown).
module hex_display_ctrl #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned DEBOUNCE = 500000
) (
    input logic               clk,
    input logic               rst,
    hex_display_ctrl_if.slave io
);
    localparam int unsigned NB = 4 * DIGITS;
    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    if (WIDTH == 0 || WIDTH > NB) begin : g_bad_width
        $error("hex_display_ctrl: WIDTH must be within 1..4*DIGITS");
    end
    if (DEBOUNCE == 0) begin : g_bad_debounce
        $error("hex_display_ctrl: DEBOUNCE must be at least 1");
    end

    logic [WIDTH-1:0] sw_s1_q, sw_s2_q;
    logic             btn_s1_q, btn_s2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bcand_q, bcand_d;
    logic [CW-1:0]    bcnt_q, bcnt_d;
    logic             btn_db_q, btn_db_d;
    logic             frozen_q, frozen_d;
    logic [WIDTH-1:0] shown_q, shown_d;
    logic             changed_q, changed_d;

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        bcand_d   = bcand_q;
        bcnt_d    = bcnt_q;
        btn_db_d  = btn_db_q;
        frozen_d  = frozen_q;
        shown_d   = shown_q;
        changed_d = 1'b0;

        if (sw_s2_q != cand_q) begin
            cand_d = sw_s2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (btn_s2_q != bcand_q) begin
            bcand_d = btn_s2_q;
            bcnt_d  = '0;
        end else if (bcnt_q != CNT_MAX) begin
            bcnt_d = bcnt_q + CW'(1);
        end

        // Load uses the pre-edge frozen flag, so a coincident freeze-on still lets this value through.
        if (cnt_q == CNT_MAX && !frozen_q) begin
            shown_d   = cand_q;
            changed_d = (cand_q != shown_q);
        end

        if (bcnt_q == CNT_MAX) begin
            btn_db_d = bcand_q;
            if (bcand_q && !btn_db_q) begin
                frozen_d = !frozen_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
            cand_q    <= '0;
            cnt_q     <= '0;
            bcand_q   <= 1'b0;
            bcnt_q    <= '0;
            btn_db_q  <= 1'b0;
            frozen_q  <= 1'b0;
            shown_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            sw_s1_q   <= io.sw;
            sw_s2_q   <= sw_s1_q;
            btn_s1_q  <= io.freeze_btn;
            btn_s2_q  <= btn_s1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            bcand_q   <= bcand_d;
            bcnt_q    <= bcnt_d;
            btn_db_q  <= btn_db_d;
            frozen_q  <= frozen_d;
            shown_q   <= shown_d;
            changed_q <= changed_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    logic [NB-1:0]       shown_ext;
    logic [7*DIGITS-1:0] hex_v;

    always_comb begin
        shown_ext = '0;
        shown_ext[WIDTH-1:0] = shown_q;
        hex_v = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            hex_v[7*i +: 7] = seg7(shown_ext[4*i +: 4]);
`ifdef HEX_BLANK_EN
            if (i != 0 && (shown_ext >> (4*i)) == '0) begin
                hex_v[7*i +: 7] = '1;
            end
`endif
        end
    end

    assign io.hex     = hex_v;
    assign io.frozen  = frozen_q;
    assign io.changed = changed_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with a sample-history reference model.
// Build with HEX_BLANK_EN defined to cover leading-zero blanking.
module tb_hex_display_ctrl;
    localparam int unsigned WIDTH    = 10;
    localparam int unsigned DIGITS   = 3;
    localparam int unsigned DEBOUNCE = 4;
    localparam int unsigned HD       = DEBOUNCE + 2;
`ifdef HEX_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam logic [6:0] Z_HI = BLANK ? 7'b1111111 : 7'b1000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hex_display_ctrl_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    hex_display_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS), .DEBOUNCE(DEBOUNCE)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [7*DIGITS-1:0] model_hex(input logic [WIDTH-1:0] v);
        int unsigned val, top, d;
        logic [7*DIGITS-1:0] r;
        val = v;
        top = 0;
        r   = '0;
        for (int unsigned i = 0; i < DIGITS; i++)
            if (((val >> (4*i)) & 15) != 0) top = i;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = (val >> (4*i)) & 15;
            r[7*i +: 7] = (BLANK && i > top) ? 7'b1111111 : seg_tab[d];
        end
        return r;
    endfunction

    // Reference model: a value is accepted once the samples taken DEBOUNCE+2 .. 3
    // edges ago all agree; reset behaves like three zero samples just taken.
    logic [WIDTH-1:0] hv [HD];
    logic             hb [HD];
    int               m_nv;
    logic [WIDTH-1:0] m_shown;
    logic             m_btn, m_frozen, m_changed;

    function automatic bit v_window_ok();
        bit ok;
        ok = (m_nv >= int'(HD));
        for (int k = 3; k < int'(HD); k++) if (hv[k] != hv[2]) ok = 1'b0;
        return ok;
    endfunction

    function automatic bit b_window_ok();
        bit ok;
        ok = (m_nv >= int'(HD));
        for (int k = 3; k < int'(HD); k++) if (hb[k] != hb[2]) ok = 1'b0;
        return ok;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(HD); k++) begin
                hv[k] <= '0;
                hb[k] <= 1'b0;
            end
            m_nv      <= 3;
            m_shown   <= '0;
            m_btn     <= 1'b0;
            m_frozen  <= 1'b0;
            m_changed <= 1'b0;
        end else begin
            m_changed <= 1'b0;
            if (v_window_ok() && !m_frozen) begin
                m_shown   <= hv[2];
                m_changed <= (hv[2] != m_shown);
            end
            if (b_window_ok()) begin
                m_btn <= hb[2];
                if (hb[2] && !m_btn) m_frozen <= !m_frozen;
            end
            for (int k = int'(HD) - 1; k > 0; k--) begin
                hv[k] <= hv[k-1];
                hb[k] <= hb[k-1];
            end
            hv[0] <= bus.sw;
            hb[0] <= bus.freeze_btn;
            if (m_nv < int'(HD)) m_nv <= m_nv + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_hex",     32'(bus.hex),     32'(model_hex(m_shown)));
            check("model_frozen",  32'(bus.frozen),  32'(m_frozen));
            check("model_changed", 32'(bus.changed), 32'(m_changed));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_sw(input logic [WIDTH-1:0] v);
        @(negedge clk);
        bus.sw = v;
    endtask

    localparam logic [20:0] HEX_ZERO = {Z_HI, Z_HI, 7'b1000000};

    initial begin
        bus.sw = '0;
        bus.freeze_btn = 1'b0;
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        #2;
        check("reset_hex",     32'(bus.hex),     32'(HEX_ZERO));
        check("reset_frozen",  32'(bus.frozen),  32'd0);
        check("reset_changed", 32'(bus.changed), 32'd0);

        // sw = 0x00F right at reset release
        @(negedge clk);
        rst = 1'b0;
        bus.sw = 10'h00F;
        edges(6);
        check("t1_edge6_hex", 32'(bus.hex), 32'(HEX_ZERO));
        edges(1);
        check("t1_edge7_hex", 32'(bus.hex), 32'({Z_HI, Z_HI, 7'b0001110}));
        check("t1_changed",   32'(bus.changed), 32'd1);
        edges(1);
        check("t1_changed_end", 32'(bus.changed), 32'd0);

        drive_sw(10'h3FF);
        edges(7);
        check("t2_hex",     32'(bus.hex), 32'({7'b0110000, 7'b0001110, 7'b0001110}));
        check("t2_changed", 32'(bus.changed), 32'd1);
        drive_sw(10'h3FF);
        repeat (10) begin
            edges(1);
            check("t2_reapply_changed", 32'(bus.changed), 32'd0);
        end

        drive_sw(10'h000);
        edges(10);
        drive_sw(10'h155);
        @(negedge clk);
        @(negedge clk);
        bus.sw = 10'h000;
        repeat (12) begin
            edges(1);
            check("t3_glitch_changed", 32'(bus.changed), 32'd0);
            check("t3_glitch_hex",     32'(bus.hex),     32'(HEX_ZERO));
        end

        @(negedge clk);
        bus.freeze_btn = 1'b1;
        edges(6);
        check("t4_frozen_edge6", 32'(bus.frozen), 32'd0);
        edges(1);
        check("t4_frozen_edge7", 32'(bus.frozen), 32'd1);
        edges(1);
        @(negedge clk);
        bus.freeze_btn = 1'b0;
        edges(12);
        drive_sw(10'h03F);
        edges(12);
        check("t4_hold_hex",    32'(bus.hex),    32'(HEX_ZERO));
        check("t4_hold_frozen", 32'(bus.frozen), 32'd1);
        @(negedge clk);
        bus.freeze_btn = 1'b1;
        edges(7);
        check("t4_unfreeze", 32'(bus.frozen), 32'd0);
        check("t4_unfreeze_hex_pre", 32'(bus.hex), 32'(HEX_ZERO));
        edges(1);
        check("t4_unfreeze_hex", 32'(bus.hex), 32'({Z_HI, 7'b0110000, 7'b0001110}));
        check("t4_unfreeze_changed", 32'(bus.changed), 32'd1);
        @(negedge clk);
        bus.freeze_btn = 1'b0;
        edges(12);

        drive_sw(10'h2A5);
        edges(3);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_hex",     32'(bus.hex),     32'(HEX_ZERO));
        check("t5_rst_frozen",  32'(bus.frozen),  32'd0);
        check("t5_rst_changed", 32'(bus.changed), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        edges(6);
        check("t5_edge6_hex", 32'(bus.hex), 32'(HEX_ZERO));
        edges(1);
        check("t5_edge7_hex", 32'(bus.hex), 32'({7'b0100100, 7'b0001000, 7'b0010010}));
        check("t5_changed",   32'(bus.changed), 32'd1);

`ifdef HEX_BLANK_EN
        drive_sw(10'h00F);
        edges(7);
        check("blank_0f_hex", 32'(bus.hex), 32'({7'b1111111, 7'b1111111, 7'b0001110}));
        drive_sw(10'h000);
        edges(7);
        check("blank_0_hex", 32'(bus.hex), 32'({7'b1111111, 7'b1111111, 7'b1000000}));
`endif

        edges(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised switch-to-seven-segment display controller for the board bring-up top level. Synchronises and debounces a WIDTH-bit switch value, holds it in a display register, and drives DIGITS active-low hexadecimal seven-segment digits. A debounced freeze button latches the shown value, and a one-cycle `changed` pulse flags every display update.

## Interface
- `WIDTH`, 10: width of switch input; must satisfy 1 ≤ WIDTH ≤ 4*DIGITS (elaboration error otherwise)
- `DIGITS`, 3: number of hex digits driven
- `DEBOUNCE`, 500000: consecutive stable cycles required before a new level is accepted; must be ≥ 1
- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-high
- `sw` in WIDTH: raw switch value, asynchronous to `clk`
- `freeze_btn` in 1: raw freeze button, active-high, asynchronous to `clk`
- `hex` out 7*DIGITS: digit i on `hex[7*i+6:7*i]`, segment order g..a (bit 6 = g), active-low
- `frozen` out 1: display hold active
- `changed` out 1: one-cycle pulse when the display register takes a new, different value

## Operation
- Two-flop synchroniser on every `sw` bit and on `freeze_btn`.
- Value debouncer: `cand` register plus counter `cnt`. If synced value ≠ `cand`: `cand` ← synced, `cnt` ← 0. Otherwise `cnt` increments, saturating at DEBOUNCE-1. When `cnt` = DEBOUNCE-1 and `frozen` = 0, `shown` ← `cand` every cycle. Reloading the same value is idempotent.
- `changed` is a registered pulse, high for the one cycle after `shown` loads a value different from its previous value.
- Button debouncer: same structure with its own counter and DEBOUNCE. Its accepted level `btn_db` updates when the counter saturates. A 0→1 transition of `btn_db` toggles `frozen`. Releasing the button has no effect.
- Unfreeze: if the value counter is already saturated, `shown` loads the current stable `cand` on the next edge, and `changed` pulses if that value differs.
- Encoding: `shown` is zero-extended to 4*DIGITS bits. Digit i = bits [4i+3:4i]. Segment patterns are combinational from `shown`:
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000
  - 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000
  - 8 → 0000000, 9 → 0010000, A → 0001000, b → 0000011
  - C → 1000110, d → 0100001, E → 0000110, F → 0001110
- Reset values (immediate on `rst` high):
  - `shown` = 0, `cand` = 0, both counters = 0, `btn_db` = 0, synchronisers = 0
  - `frozen` = 0, `changed` = 0
  - every digit = 1000000 (subject to blanking, see Configuration)
- Reset asserted mid-debounce discards the pending candidate. No update occurs until a full DEBOUNCE window passes after reset release.

## Timing
- Value latency: with a stable new `sw` and `frozen` = 0, `shown` and `hex` change at rising edge DEBOUNCE+3, counting the edge that first samples the new value as edge 1. `changed` is high during the cycle after that edge.
- An input glitch shorter than DEBOUNCE cycles at the synchroniser output never reaches `shown`.
- `frozen` toggles at edge DEBOUNCE+3 after a stable button press is first sampled.
- Simultaneous value acceptance and freeze toggle-on in the same edge: the value load wins, so `shown` updates, then the hold takes effect.
- `hex` is combinational from registered state only, with no path from `sw`.

## Configuration
- `HEX_BLANK_EN` defined: leading-zero blanking. Every digit above the most significant non-zero digit outputs 1111111. Digit 0 is never blanked, so a value of 0 shows a single "0". At reset, digit 0 = 1000000 and all others = 1111111.
- Undefined: all DIGITS digits are always driven, with leading zeros shown.

## Test plan
Bench parameters: DEBOUNCE = 4, WIDTH = 10, DIGITS = 3, blanking off unless stated.
- Reset, then `sw` = 0x00F held: `hex` unchanged through edge 6; at edge 7 digit0 = 0001110, digit1 = digit2 = 1000000; `changed` high one cycle.
- `sw` = 0x3FF held: digits = 0110000, 0001110, 0001110 (2..0); then `sw` = 0x3FF re-applied produces no `changed` pulse.
- `sw` toggles 0x000→0x155→0x000 with the 0x155 phase lasting 2 cycles: `shown` stays 0, no `changed`.
- Press `freeze_btn` for 8 cycles: `frozen` = 1 at edge 7. Then `sw` = 0x03F: display holds. Press again: `frozen` = 0, display shows 0x03F (digit1 = 0110000, digit0 = 0001110) the next edge, `changed` pulses.
- Assert `rst` mid-debounce of 0x2A5: outputs return to reset values immediately. After release, 0x2A5 appears 7 edges later.
- `HEX_BLANK_EN` defined, `sw` = 0x00F: digit0 = 0001110, digit1 = digit2 = 1111111. `sw` = 0: digit0 = 1000000, others blank.
